// File: rtl/drp_pkg.sv
// Shared constants and types for the DRP responder: register map, CFG reset values, FSM states.
// No logic; imported by the responder and its conversion sequencer.
package drp_pkg;

  localparam logic [6:0] ADDR_VAUX4  = 7'h14;
  localparam logic [6:0] ADDR_VAUX12 = 7'h1C;
  localparam logic [6:0] ADDR_CFG0   = 7'h40;
  localparam logic [6:0] ADDR_CFG1   = 7'h41;
  localparam logic [6:0] ADDR_CFG2   = 7'h42;

  localparam logic [15:0] CFG0_RST = 16'h0000;
  localparam logic [15:0] CFG1_RST = 16'h0001;
  localparam logic [15:0] CFG2_RST = 16'h0400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/drp_conv_seq.sv
// Periodic conversion sequencer: one registered eoc pulse every EOC_PERIOD enabled cycles, alternating VAUX4/VAUX12.
// cap is a combinational one-hot strobe {vaux12, vaux4} aligned with the edge that raises eoc; no backpressure.
module drp_conv_seq
  import drp_pkg::*;
#(
  parameter int unsigned EOC_PERIOD = 100
) (
  input  logic       sysclk,
  input  logic       rstn,
  input  logic       seq_en,
  output logic       eoc,
  output logic [4:0] chan,
  output logic [1:0] cap
);

  localparam int unsigned CW = $clog2(EOC_PERIOD);

  logic [CW-1:0] cnt;
  logic          next_hi;
  logic          wrap;

  assign wrap = seq_en && (cnt == CW'(EOC_PERIOD - 1));
  assign cap  = {wrap & next_hi, wrap & ~next_hi};

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      next_hi <= 1'b0;
      eoc     <= 1'b0;
      chan    <= '0;
    end else begin
      eoc <= wrap;
      // Disabled sequencer freezes mid-period so re-enabling resumes the same phase.
      if (seq_en) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
      if (wrap) begin
        chan    <= next_hi ? ADDR_VAUX12[4:0] : ADDR_VAUX4[4:0];
        next_hi <= ~next_hi;
      end
    end
  end

endmodule

// File: rtl/drp_responder.sv
// DRP target standing in for the XADC macro: register file, read mux and fixed-latency transaction FSM.
// drdy_out LATENCY cycles after an accepted den_in; den_in while busy is dropped and flagged on err_out.
module drp_responder
  import drp_pkg::*;
#(
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned EOC_PERIOD = 100
) (
  input  logic        sysclk,
  input  logic        rstn,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [6:0]  daddr_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        busy_out,
  output logic        err_out,
  output logic        eoc_out,
  output logic [4:0]  channel_out,
  input  logic [11:0] vaux4_sample,
  input  logic [11:0] vaux12_sample
);

  state_t      state, state_n;
  logic [3:0]  lat_cnt, lat_cnt_n;
  logic        accept;

  logic        wr_q;
  logic [6:0]  addr_q;
  logic [15:0] wdat_q;
  logic [15:0] rdat_q;
  logic [15:0] rd_mux;

  logic [15:0] cfg0, cfg1, cfg2;
  logic [11:0] res4, res12;
  logic [1:0]  cap;

  drp_conv_seq #(
    .EOC_PERIOD(EOC_PERIOD)
  ) u_seq (
    .sysclk (sysclk),
    .rstn   (rstn),
    .seq_en (cfg1[0]),
    .eoc    (eoc_out),
    .chan   (channel_out),
    .cap    (cap)
  );

  always_comb begin
    rd_mux = '0;
    case (daddr_in)
      ADDR_VAUX4:  rd_mux = {res4, 4'h0};
      ADDR_VAUX12: rd_mux = {res12, 4'h0};
      ADDR_CFG0:   rd_mux = cfg0;
      ADDR_CFG1:   rd_mux = cfg1;
      ADDR_CFG2:   rd_mux = cfg2;
      default:     rd_mux = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    lat_cnt_n = lat_cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (den_in) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n   = WAIT;
            lat_cnt_n = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        lat_cnt_n = lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) begin
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      do_out   <= '0;
      drdy_out <= 1'b0;
      busy_out <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      state    <= state_n;
      lat_cnt  <= lat_cnt_n;
      drdy_out <= (state_n == RESP);
      busy_out <= (state_n != IDLE);
      err_out  <= den_in && (state != IDLE);
      if (accept) begin
        wr_q   <= dwe_in;
        addr_q <= daddr_in;
        wdat_q <= di_in;
        rdat_q <= rd_mux;
      end
      // With LATENCY=1 the snapshot and RESP entry share an edge, so bypass rdat_q.
      if (state_n == RESP) begin
        do_out <= accept ? rd_mux : rdat_q;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      cfg0  <= CFG0_RST;
      cfg1  <= CFG1_RST;
      cfg2  <= CFG2_RST;
      res4  <= '0;
      res12 <= '0;
    end else begin
      if (state == RESP && wr_q) begin
        case (addr_q)
          ADDR_CFG0: cfg0 <= wdat_q;
          ADDR_CFG1: cfg1 <= wdat_q;
          ADDR_CFG2: cfg2 <= wdat_q;
          default:   ;
        endcase
      end
      if (cap[0]) res4  <= vaux4_sample;
      if (cap[1]) res12 <= vaux12_sample;
    end
  end

endmodule
